// File: rtl/uart_boot_loader.sv
// Serial boot loader: polls the UART register port, parses MAGIC/LEN/BASE/payload and writes words to memory.
// Define UART_LOADER_ACK_EN to return the 8-bit checksum to the host before releasing the CPU.
module uart_boot_loader #(
  parameter logic [7:0] MAGIC = 8'h55
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        u_ce,
  output logic [1:0]  u_addr,
  output logic        u_read,
  output logic        u_write,
  output logic [31:0] u_wdata,
  input  logic [31:0] u_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done
);
  typedef enum logic [3:0] {
    IDLE, RV_REQ, RV_WAIT, RV_CHK, RB_REQ, RB_WAIT, RB_TAKE, WR_MEM,
    TX_REQ, TX_WAIT, TX_CHK, TX_SEND, DONE
  } state_e;
  typedef enum logic [1:0] {PH_MAGIC, PH_LEN, PH_BASE, PH_DATA} phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] len_q, len_d, base_q, base_d;
  logic        u_ce_q, u_read_q, u_read_d, u_write_q, u_write_d, mem_we_q, mem_we_d;
  logic [1:0]  u_addr_q, u_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        go_poll, go_end;
  logic [7:0]  rx_byte;
  logic        unused_rdata;

  assign rx_byte      = u_rdata[7:0];
  assign unused_rdata = ^u_rdata[31:8];

`ifdef UART_LOADER_ACK_EN
  logic [7:0]  csum_q, csum_d;
  logic [31:0] u_wdata_q, u_wdata_d;
  assign u_write = u_write_q;
  assign u_wdata = u_wdata_q;
`else
  assign u_write = 1'b0;
  assign u_wdata = '0;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bidx_d      = bidx_q;
    len_d       = len_q;
    base_d      = base_q;
    u_read_d    = 1'b0;
    u_write_d   = 1'b0;
    u_addr_d    = u_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    go_poll     = 1'b0;
    go_end      = 1'b0;
`ifdef UART_LOADER_ACK_EN
    csum_d      = csum_q;
    u_wdata_d   = u_wdata_q;
`endif
    // Strobes are launched on the transition into each *_REQ / WR_MEM / TX_SEND state.
    case (state_q)
      IDLE:    if (enable) go_poll = 1'b1;
      RV_REQ:  state_d = RV_WAIT;
      RV_WAIT: state_d = RV_CHK;
      RV_CHK: begin
        if (u_rdata[0]) begin
          state_d  = RB_REQ;
          u_read_d = 1'b1;
          u_addr_d = 2'd0;
        end else go_poll = 1'b1;
      end
      RB_REQ:  state_d = RB_WAIT;
      RB_WAIT: state_d = RB_TAKE;
      RB_TAKE: begin
        go_poll = 1'b1;
        bidx_d  = bidx_q + 2'd1;
`ifdef UART_LOADER_ACK_EN
        csum_d  = csum_q + rx_byte;
`endif
        // Multi-byte fields arrive LSB first, so shifting in from the top leaves them aligned after 4 bytes.
        case (phase_q)
          PH_MAGIC: begin
            bidx_d = 2'd0;
            if (rx_byte == MAGIC) begin
              phase_d = PH_LEN;
`ifdef UART_LOADER_ACK_EN
              csum_d  = 8'h00;
`endif
            end
`ifdef UART_LOADER_ACK_EN
            else csum_d = csum_q;
`endif
          end
          PH_LEN: begin
            len_d = {rx_byte, len_q[31:8]};
            if (bidx_q == 2'd3) phase_d = PH_BASE;
          end
          PH_BASE: begin
            base_d = {rx_byte, base_q[31:8]};
            if (bidx_q == 2'd3) begin
              phase_d    = PH_DATA;
              mem_addr_d = {base_d[31:2], 2'b00};
              if (len_q == 32'd0) begin
                go_poll = 1'b0;
                go_end  = 1'b1;
              end
            end
          end
          default: begin
            mem_wdata_d = {rx_byte, mem_wdata_q[31:8]};
            if (bidx_q == 2'd3) begin
              go_poll  = 1'b0;
              state_d  = WR_MEM;
              mem_we_d = 1'b1;
            end
          end
        endcase
      end
      WR_MEM: begin
        mem_addr_d = mem_addr_q + 32'd4;
        len_d      = len_q - 32'd1;
        if (len_q == 32'd1) go_end = 1'b1;
        else go_poll = 1'b1;
      end
`ifdef UART_LOADER_ACK_EN
      TX_REQ:  state_d = TX_WAIT;
      TX_WAIT: state_d = TX_CHK;
      TX_CHK: begin
        if (u_rdata[0]) begin
          state_d   = TX_SEND;
          u_write_d = 1'b1;
          u_addr_d  = 2'd1;
          u_wdata_d = {24'h0, csum_q};
        end else go_end = 1'b1;
      end
      TX_SEND: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (go_poll) begin
      state_d  = RV_REQ;
      u_read_d = 1'b1;
      u_addr_d = 2'd2;
    end
    if (go_end) begin
`ifdef UART_LOADER_ACK_EN
      state_d  = TX_REQ;
      u_read_d = 1'b1;
      u_addr_d = 2'd3;
`else
      state_d  = DONE;
      done_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_MAGIC;
      bidx_q      <= 2'd0;
      len_q       <= '0;
      base_q      <= '0;
      u_ce_q      <= 1'b0;
      u_read_q    <= 1'b0;
      u_write_q   <= 1'b0;
      u_addr_q    <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef UART_LOADER_ACK_EN
      csum_q      <= 8'h00;
      u_wdata_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bidx_q      <= bidx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      u_ce_q      <= u_read_d | u_write_d;
      u_read_q    <= u_read_d;
      u_write_q   <= u_write_d;
      u_addr_q    <= u_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef UART_LOADER_ACK_EN
      csum_q      <= csum_d;
      u_wdata_q   <= u_wdata_d;
`endif
    end
  end

  assign u_ce      = u_ce_q;
  assign u_addr    = u_addr_q;
  assign u_read    = u_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign done      = done_q;
  assign cpu_hold  = !done_q;
endmodule
